inst_mem_arbiter: RTL and testbench
===================================

// Module: inst_mem_arbiter
// PURPOSE
//   Shares one synchronous-read instruction memory between two requesters:
//   port 0 = CPU instruction fetch (read-only), port 1 = loader/debug
//   (read/write). Sits between the IF stage / debug unit and the memory.
//   Grants at most one access per cycle, keeps streaks to one owner
//   (bounded by LOCK_MAX) and returns read data one cycle after grant.
// PARAMETERS
//   ADDR_W    32  byte-address width of both ports and the memory
//   DATA_W    32  data width (one instruction word)
//   LOCK_MAX  4   max consecutive grants to one port while the other waits
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous reset, active low
//   m0_req     in   1       fetch request, held until m0_gnt
//   m0_addr    in   ADDR_W  fetch byte address, must be word aligned
//   m0_gnt     out  1       fetch accepted this cycle (combinational)
//   m0_rvalid  out  1       fetch data valid (cycle after m0_gnt)
//   m0_rdata   out  DATA_W  fetch data
//   m0_err     out  1       with m0_rvalid: fetch was misaligned
//   m1_req     in   1       loader request, held until m1_gnt
//   m1_we      in   1       1 = write, 0 = read
//   m1_addr    in   ADDR_W  loader byte address (word aligned)
//   m1_wdata   in   DATA_W  write data
//   m1_gnt     out  1       loader accepted this cycle (combinational)
//   m1_rvalid  out  1       loader response (read data or write ack)
//   m1_rdata   out  DATA_W  loader read data; 0 for write acks
//   mem_ce     out  1       memory chip enable
//   mem_we     out  1       memory write enable
//   mem_addr   out  ADDR_W  memory byte address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data, valid cycle after mem_ce
// BEHAVIOUR
//   - Reset (rst_n=0, async): state IDLE, streak=0, all rvalid/err=0,
//     all rdata=0; gnt and mem_* outputs are 0 while rst_n=0.
//   - FSM states (last owner): IDLE, OWN0, OWN1. Registered.
//     IDLE: m0_req -> grant 0, go OWN0; else m1_req -> grant 1, go OWN1.
//     OWNx: owner req -> grant owner unless other req && streak==LOCK_MAX,
//       then grant other, go OWNother, streak=1. Owner idle & other req ->
//       grant other. No req -> go IDLE, streak=0.
//   - streak: +1 per consecutive grant to same owner, saturates LOCK_MAX;
//     reset to 1 on owner change.
//   - Issue cycle T: gnt and mem_ce/we/addr/wdata driven combinationally
//     from granted port; mem_we = m1_we for port 1, always 0 for port 0.
//   - Response at T+1: rvalid=1 for one cycle to granted port; rdata =
//     mem_rdata for reads, 0 for writes. Back-to-back grants every cycle.
//   - Misaligned fetch (m0_addr[1:0]!=0): m0_gnt=1, mem_ce=0 for that
//     cycle (slot not given to port 1), T+1 m0_rvalid=1, m0_err=1, rdata=0.
//     Counts as a port-0 grant for streak.
//   - Port 1 misalignment: low 2 address bits passed through unchecked.
//   - Dropping req before gnt is legal; no response produced.
//   - Reset mid-access: pending response discarded, no rvalid after reset.
// TESTING
//   - Reset: rst_n=0 mid-stream -> rvalid/err/gnt/mem_ce 0 immediately.
//   - Fetch only, addr 0,4,8 each cycle -> gnt each cycle, m0_rdata =
//     mem words at 0,4,8 one cycle later, m1_rvalid=0.
//   - Both req continuously, LOCK_MAX=4, start IDLE -> grants 0,0,0,0,1,
//     1,1,1,0... ; IDLE tie goes to port 0.
//   - Loader write 0xDEADBEEF @0x10, then fetch 0x10 -> mem_we=1 on write
//     only, m1_rdata=0 ack, m0_rdata=0xDEADBEEF.
//   - Fetch addr 0x6 -> mem_ce=0, next cycle m0_rvalid=1, m0_err=1, rdata=0.
//   - m0 req dropped before gnt while m1 owns -> no m0_rvalid ever.

Source files
------------

// File: rtl/inst_mem_arbiter.sv
// Two-port arbiter in front of one synchronous-read instruction memory.
// Port 0 is the CPU fetch path (read-only), port 1 the loader/debug path
// (read/write). One access per cycle, owner streaks bounded by LOCK_MAX,
// responses returned one cycle after the grant.
module inst_mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // port 0: instruction fetch
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    // port 1: loader / debug
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    // memory side
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned STREAK_W = $clog2(LOCK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(LOCK_MAX);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    // response pipeline: one stage, matches the memory read latency
    logic rvalid0_q, rvalid0_d;
    logic err0_q, err0_d;
    logic rvalid1_q, rvalid1_d;
    logic rd1_q, rd1_d;

    logic arb0, arb1;
    logic gnt0, gnt1;
    logic lock_hit;
    logic m0_misalign;

    assign lock_hit    = (streak_q == STREAK_MAX);
    assign m0_misalign = (m0_addr[1:0] != 2'b00);

    // Arbitration: owner keeps the slot unless the other side has waited out a full streak
    always_comb begin
        arb0 = 1'b0;
        arb1 = 1'b0;
        case (state_q)
            ST_OWN0: begin
                if (m0_req && !(m1_req && lock_hit)) begin
                    arb0 = 1'b1;
                end else if (m1_req) begin
                    arb1 = 1'b1;
                end
            end
            ST_OWN1: begin
                if (m1_req && !(m0_req && lock_hit)) begin
                    arb1 = 1'b1;
                end else if (m0_req) begin
                    arb0 = 1'b1;
                end
            end
            default: begin
                if (m0_req) begin
                    arb0 = 1'b1;
                end else if (m1_req) begin
                    arb1 = 1'b1;
                end
            end
        endcase
    end

    // Grants are forced low while reset is asserted
    assign gnt0 = arb0 & rst_n;
    assign gnt1 = arb1 & rst_n;

    // Next owner, streak counter and response flags
    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        rvalid0_d = 1'b0;
        err0_d    = 1'b0;
        rvalid1_d = 1'b0;
        rd1_d     = 1'b0;
        if (gnt0) begin
            state_d   = ST_OWN0;
            rvalid0_d = 1'b1;
            err0_d    = m0_misalign;
            if (state_q == ST_OWN0) begin
                streak_d = lock_hit ? STREAK_MAX : streak_q + STREAK_ONE;
            end else begin
                streak_d = STREAK_ONE;
            end
        end else if (gnt1) begin
            state_d   = ST_OWN1;
            rvalid1_d = 1'b1;
            rd1_d     = ~m1_we;
            if (state_q == ST_OWN1) begin
                streak_d = lock_hit ? STREAK_MAX : streak_q + STREAK_ONE;
            end else begin
                streak_d = STREAK_ONE;
            end
        end else begin
            state_d  = ST_IDLE;
            streak_d = '0;
        end
    end

    // State, streak and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            streak_q  <= '0;
            rvalid0_q <= 1'b0;
            err0_q    <= 1'b0;
            rvalid1_q <= 1'b0;
            rd1_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            rvalid0_q <= rvalid0_d;
            err0_q    <= err0_d;
            rvalid1_q <= rvalid1_d;
            rd1_q     <= rd1_d;
        end
    end

    // Memory issue: misaligned fetches consume the slot without touching memory
    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_ce   = ~m0_misalign;
            mem_addr = m0_misalign ? '0 : m0_addr;
        end else if (gnt1) begin
            mem_ce    = 1'b1;
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // Responses: memory data is already aligned with the registered valid
    assign m0_rvalid = rvalid0_q;
    assign m0_err    = err0_q;
    assign m0_rdata  = (rvalid0_q && !err0_q) ? mem_rdata : '0;
    assign m1_rvalid = rvalid1_q;
    assign m1_rdata  = rd1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Directed self-checking bench for inst_mem_arbiter with a small
// synchronous-read memory model behind the arbiter.
module tb_inst_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m0_err;
    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    inst_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: word i preloaded with 32'hC0DE0000 + i
    logic [31:0] mem [0:63];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
            mem_loaded <= 1'b1;
        end else if (mem_ce) begin
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; m0_req = 1'b1; m0_addr = 32'h0; m1_req = 1'b1;
        m1_we = 1'b0; m1_addr = 32'hC; m1_wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m0_gnt: got %b expected 0", m0_gnt); end
        n_checks++; if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_m1_gnt: got %b expected 0", m1_gnt); end
        n_checks++; if (mem_ce !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ce: got %b expected 0", mem_ce); end
        n_checks++; if (m0_rvalid !== 1'b0 || m0_err !== 1'b0) begin n_fail++; $display("FAIL reset_m0_rsp: got rvalid=%b err=%b expected 0 0", m0_rvalid, m0_err); end
        n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m1_rvalid: got %b expected 0", m1_rvalid); end
        n_checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata); end
        @(negedge clk);
        rst_n = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
        #1;
        n_checks++; if (m0_gnt !== 1'b0 || mem_ce !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got gnt=%b ce=%b expected 0 0", m0_gnt, mem_ce); end
    endtask

    task automatic test_fetch_stream();
        logic [31:0] addrs [0:2];
        logic [31:0] exp   [0:2];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        exp[0] = 32'hC0DE_0000; exp[1] = 32'hC0DE_0001; exp[2] = 32'hC0DE_0002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m0_req  = (i < 3);
            m0_addr = (i < 3) ? addrs[i] : 32'h0;
            #1;
            if (i < 3) begin
                n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL fetch_gnt[%0d]: got %b expected 1", i, m0_gnt); end
                n_checks++; if (mem_ce !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addrs[i]) begin n_fail++; $display("FAIL fetch_issue[%0d]: got ce=%b we=%b addr=%h expected 1 0 %h", i, mem_ce, mem_we, mem_addr, addrs[i]); end
            end
            if (i > 0) begin
                n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== exp[i-1]) begin n_fail++; $display("FAIL fetch_rsp[%0d]: got rvalid=%b rdata=%h expected 1 %h", i-1, m0_rvalid, m0_rdata, exp[i-1]); end
            end
            n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_m1_rvalid[%0d]: got %b expected 0", i, m1_rvalid); end
        end
    endtask

    task automatic test_arbitration();
        // bit i set => cycle i granted to port 1
        logic [8:0] pat;
        logic       prev1;
        pat   = 9'b0_1111_0000;
        prev1 = 1'b0;
        m1_we = 1'b0; m0_addr = 32'h0; m1_addr = 32'hC;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            m0_req = (i < 9);
            m1_req = (i < 9);
            #1;
            if (i < 9) begin
                n_checks++; if (m0_gnt !== ~pat[i] || m1_gnt !== pat[i]) begin n_fail++; $display("FAIL arb_gnt[%0d]: got m0=%b m1=%b expected m0=%b m1=%b", i, m0_gnt, m1_gnt, ~pat[i], pat[i]); end
            end
            if (i > 0) begin
                if (prev1) begin
                    n_checks++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 32'hC0DE_0003) begin n_fail++; $display("FAIL arb_rsp1[%0d]: got v0=%b v1=%b rdata=%h expected 0 1 c0de0003", i-1, m0_rvalid, m1_rvalid, m1_rdata); end
                end else begin
                    n_checks++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 32'hC0DE_0000) begin n_fail++; $display("FAIL arb_rsp0[%0d]: got v0=%b v1=%b rdata=%h expected 1 0 c0de0000", i-1, m0_rvalid, m1_rvalid, m0_rdata); end
                end
            end
            if (i < 9) prev1 = pat[i];
        end
    endtask

    task automatic test_write_then_fetch();
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL wr_gnt: got m1=%b m0=%b expected 1 0", m1_gnt, m0_gnt); end
        n_checks++; if (mem_ce !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_issue: got ce=%b we=%b addr=%h wdata=%h expected 1 1 10 deadbeef", mem_ce, mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        m1_req = 1'b0; m1_we = 1'b0; m0_req = 1'b1; m0_addr = 32'h10;
        #1;
        n_checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_ack: got rvalid=%b rdata=%h expected 1 0", m1_rvalid, m1_rdata); end
        n_checks++; if (m0_gnt !== 1'b1 || mem_we !== 1'b0 || mem_ce !== 1'b1) begin n_fail++; $display("FAIL rd_issue: got gnt=%b we=%b ce=%b expected 1 0 1", m0_gnt, mem_we, mem_ce); end
        @(negedge clk);
        m0_req = 1'b0;
        #1;
        n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_back: got rvalid=%b rdata=%h expected 1 deadbeef", m0_rvalid, m0_rdata); end
        n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_back_m1: got %b expected 0", m1_rvalid); end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 32'h6; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hC;
        #1;
        n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL mis_gnt: got m0=%b m1=%b expected 1 0", m0_gnt, m1_gnt); end
        n_checks++; if (mem_ce !== 1'b0) begin n_fail++; $display("FAIL mis_ce: got %b expected 0", mem_ce); end
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0; m0_addr = 32'h0;
        #1;
        n_checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1) begin n_fail++; $display("FAIL mis_rsp: got rvalid=%b err=%b expected 1 1", m0_rvalid, m0_err); end
        n_checks++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_rdata: got %h expected 0", m0_rdata); end
        n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL mis_m1_rvalid: got %b expected 0", m1_rvalid); end
        @(negedge clk);
        #1;
        n_checks++; if (m0_err !== 1'b0 || m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got rvalid=%b err=%b expected 0 0", m0_rvalid, m0_err); end
    endtask

    task automatic test_drop();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            m1_req  = (i < 5);
            m1_we   = 1'b0;
            m1_addr = 32'hC;
            m0_req  = (i == 1);
            m0_addr = 32'h0;
            #1;
            if (i < 5) begin
                n_checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL drop_gnt[%0d]: got m0=%b m1=%b expected 0 1", i, m0_gnt, m1_gnt); end
            end
            n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL drop_m0_rvalid[%0d]: got %b expected 0", i, m0_rvalid); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        m0_req = 1'b1; m0_addr = 32'h4;
        #1;
        n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b expected 1", m0_gnt); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0 || mem_ce !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: got rvalid=%b gnt=%b ce=%b expected 0 0 0", m0_rvalid, m0_gnt, mem_ce); end
        @(negedge clk);
        rst_n = 1'b1; m0_req = 1'b0;
        #1;
        n_checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got v0=%b v1=%b expected 0 0", m0_rvalid, m1_rvalid); end
        @(negedge clk);
        #1;
        n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_after2: got %b expected 0", m0_rvalid); end
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_arbitration();
        test_write_then_fetch();
        test_misaligned();
        test_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
